// File: rtl/pump_activity_monitor_if.sv
// rtl/pump_activity_monitor_if.sv - pump drive/clear inputs and per-channel statistics bundle
interface pump_activity_monitor_if;
  logic [1:0]  pump_in;
  logic        clear;
  logic [15:0] act_count0;
  logic [15:0] act_count1;
  logic [15:0] last_on_sec0;
  logic [15:0] last_on_sec1;
  logic [1:0]  fault;
  logic [1:0]  event_valid;

  modport master (
    output pump_in, clear,
    input  act_count0, act_count1, last_on_sec0, last_on_sec1, fault, event_valid
  );

  modport slave (
    input  pump_in, clear,
    output act_count0, act_count1, last_on_sec0, last_on_sec1, fault, event_valid
  );
endinterface

// File: rtl/pump_activity_monitor.sv
// rtl/pump_activity_monitor.sv - two-channel pump on-time monitor with stuck-on detection
module pump_activity_monitor #(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int MAX_ON_SECONDS = 60
) (
  input logic                    clk,
  input logic                    reset,
  pump_activity_monitor_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_STUCK = 2'd2;

  localparam logic [31:0] CYC_LAST = 32'(CLOCK_FREQ - 1);
  localparam logic [15:0] MAX_SEC  = 16'(MAX_ON_SECONDS);

  logic [1:0]       pump_prev_q;
  logic [1:0][1:0]  state_q, state_d;
  logic [1:0][31:0] cyc_q, cyc_d;
  logic [1:0][15:0] sec_q, sec_d;
  logic [1:0][15:0] act_q, act_d;
  logic [1:0][15:0] last_q, last_d;
  logic [1:0]       fault_q, fault_d;
  logic [1:0]       evt_q, evt_d;
  logic [1:0][15:0] sec_inc;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sec_d   = sec_q;
    act_d   = act_q;
    last_d  = last_q;
    fault_d = fault_q;
    evt_d   = '0;
    sec_inc = '0;
    for (int n = 0; n < 2; n++) begin
      sec_inc[n] = sec_q[n] + 16'd1;
      case (state_q[n])
        ST_IDLE: begin
          if (bus.pump_in[n] && !pump_prev_q[n]) begin
            state_d[n] = ST_ON;
            cyc_d[n]   = 32'd1;
            sec_d[n]   = '0;
            if (act_q[n] != 16'hFFFF) act_d[n] = act_q[n] + 16'd1;
          end
        end
        ST_ON: begin
          if (bus.pump_in[n]) begin
            if (cyc_q[n] == CYC_LAST) begin
              cyc_d[n] = '0;
              sec_d[n] = sec_inc[n];
              // Timing freezes once stuck; the report then uses the limit itself.
              if (sec_inc[n] == MAX_SEC) begin
                state_d[n] = ST_STUCK;
                fault_d[n] = 1'b1;
              end
            end else begin
              cyc_d[n] = cyc_q[n] + 32'd1;
            end
          end else begin
            last_d[n]  = sec_q[n];
            evt_d[n]   = 1'b1;
            state_d[n] = ST_IDLE;
          end
        end
        ST_STUCK: begin
          if (!bus.pump_in[n]) begin
            last_d[n]  = MAX_SEC;
            evt_d[n]   = 1'b1;
            state_d[n] = ST_IDLE;
          end
        end
        default: state_d[n] = ST_IDLE;
      endcase
      // Clear wipes only the reported statistics; timing of a live activation continues.
      if (bus.clear) begin
        act_d[n]   = '0;
        last_d[n]  = '0;
        fault_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pump_prev_q <= '0;
      state_q     <= {ST_IDLE, ST_IDLE};
      cyc_q       <= '0;
      sec_q       <= '0;
      act_q       <= '0;
      last_q      <= '0;
      fault_q     <= '0;
      evt_q       <= '0;
    end else begin
      pump_prev_q <= bus.pump_in;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      sec_q       <= sec_d;
      act_q       <= act_d;
      last_q      <= last_d;
      fault_q     <= fault_d;
      evt_q       <= evt_d;
    end
  end

  assign bus.act_count0   = act_q[0];
  assign bus.act_count1   = act_q[1];
  assign bus.last_on_sec0 = last_q[0];
  assign bus.last_on_sec1 = last_q[1];
  assign bus.fault        = fault_q;
  assign bus.event_valid  = evt_q;

endmodule

// File: tb/tb_pump_activity_monitor.sv
// tb/tb_pump_activity_monitor.sv - directed vector bench for pump_activity_monitor (CLOCK_FREQ=10, MAX_ON_SECONDS=3)
module tb_pump_activity_monitor;

  typedef struct {
    logic        rst_n;
    logic [1:0]  pump;
    logic        clr;
    int          cnt;
    logic [15:0] a0, a1, l0, l1;
    logic [1:0]  f, ev;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  pump_activity_monitor_if bus ();

  pump_activity_monitor #(
    .CLOCK_FREQ    (10),
    .MAX_ON_SECONDS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [1:0] p, input logic c, input int n,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] l0, input logic [15:0] l1,
                     input logic [1:0] f, input logic [1:0] ev);
    vec_t v;
    v.rst_n = r; v.pump = p; v.clr = c; v.cnt = n;
    v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1; v.f = f; v.ev = ev;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " act_count0"},   bus.act_count0,   v.a0);
    chk({tag, " act_count1"},   bus.act_count1,   v.a1);
    chk({tag, " last_on_sec0"}, bus.last_on_sec0, v.l0);
    chk({tag, " last_on_sec1"}, bus.last_on_sec1, v.l1);
    chk({tag, " fault"},        16'(bus.fault),       16'(v.f));
    chk({tag, " event_valid"},  16'(bus.event_valid), 16'(v.ev));
  endtask

  task automatic step(input logic [1:0] p);
    bus.pump_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.pump_in = 2'b11;
    bus.clear   = 1'b1;

    //  rst pump  clr cnt   a0 a1 l0 l1 fault ev
    add(0, 2'b11, 1,  2,    0, 0, 0, 0, 2'b00, 2'b00); // reset beats clear and pump
    add(1, 2'b01, 0, 25,    1, 0, 0, 0, 2'b00, 2'b00); // 25 high samples
    add(1, 2'b00, 0,  1,    1, 0, 2, 0, 2'b00, 2'b01);
    add(1, 2'b00, 0,  1,    1, 0, 2, 0, 2'b00, 2'b00);
    add(1, 2'b10, 0, 29,    1, 1, 2, 0, 2'b00, 2'b00); // one sample short of stuck
    add(1, 2'b10, 0,  1,    1, 1, 2, 0, 2'b10, 2'b00); // 30th sample -> stuck
    add(1, 2'b10, 0, 10,    1, 1, 2, 0, 2'b10, 2'b00);
    add(1, 2'b00, 0,  1,    1, 1, 2, 3, 2'b10, 2'b10);
    add(1, 2'b00, 0,  1,    1, 1, 2, 3, 2'b10, 2'b00);
    add(1, 2'b11, 0,  9,    2, 2, 2, 3, 2'b10, 2'b00); // both channels, under a second
    add(1, 2'b00, 0,  1,    2, 2, 0, 0, 2'b10, 2'b11);
    add(1, 2'b00, 0,  1,    2, 2, 0, 0, 2'b10, 2'b00);
    add(1, 2'b01, 0,  5,    3, 2, 0, 0, 2'b10, 2'b00);
    add(1, 2'b01, 1,  1,    0, 0, 0, 0, 2'b00, 2'b00); // clear mid-activation
    add(1, 2'b01, 0,  9,    0, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b00, 0,  1,    0, 0, 1, 0, 2'b00, 2'b01); // 15 samples -> 1 s
    add(1, 2'b00, 0,  1,    0, 0, 1, 0, 2'b00, 2'b00);
    add(1, 2'b01, 0, 11,    1, 0, 1, 0, 2'b00, 2'b00);
    add(0, 2'b01, 0,  1,    0, 0, 0, 0, 2'b00, 2'b00); // reset on 12th high sample
    add(1, 2'b01, 0,  1,    1, 0, 0, 0, 2'b00, 2'b00); // high after reset is a rising edge
    add(1, 2'b00, 0,  1,    1, 0, 0, 0, 2'b00, 2'b01);
    add(1, 2'b00, 0,  1,    1, 0, 0, 0, 2'b00, 2'b00);
    add(1, 2'b10, 0, 30,    1, 1, 0, 0, 2'b10, 2'b00);
    add(1, 2'b10, 1,  1,    0, 0, 0, 0, 2'b00, 2'b00); // clear while stuck
    add(1, 2'b10, 0,  5,    0, 0, 0, 0, 2'b00, 2'b00); // fault not re-raised
    add(1, 2'b00, 0,  1,    0, 0, 0, 3, 2'b00, 2'b10);
    add(1, 2'b00, 0,  1,    0, 0, 0, 3, 2'b00, 2'b00);

    foreach (tbl[i]) begin
      reset       = tbl[i].rst_n;
      bus.pump_in = tbl[i].pump;
      bus.clear   = tbl[i].clr;
      repeat (tbl[i].cnt) @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Saturation: one-sample pulses on channel 0, each followed by a low sample.
    begin
      vec_t sat;
      sat.rst_n = 1'b1; sat.pump = 2'b00; sat.clr = 1'b0; sat.cnt = 0;
      sat.a0 = 16'd65535; sat.a1 = 16'd0; sat.l0 = 16'd0; sat.l1 = 16'd3;
      sat.f = 2'b00; sat.ev = 2'b00;
      for (int i = 0; i < 65534; i++) begin
        step(2'b01);
        step(2'b00);
      end
      chk("sat act_count0 at 65534", bus.act_count0, 16'd65534);
      step(2'b01);
      chk("sat act_count0 at 65535", bus.act_count0, 16'd65535);
      step(2'b00);
      chk("sat event_valid", 16'(bus.event_valid), 16'd1);
      step(2'b01);
      chk("sat act_count0 held", bus.act_count0, 16'd65535);
      step(2'b00);
      step(2'b00);
      chk_all("sat final", sat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pump_activity_monitor.md
PUMP_ACTIVITY_MONITOR -- requirements
Module: pump_activity_monitor

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000, clk cycles per second; SHALL be >= 2.
REQ-002 Parameter MAX_ON_SECONDS, default 60, stuck-on limit in whole seconds; SHALL be 1..65535.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pump_in  input  2  pump drive lines, bit n = channel n, same clock domain; no synchronizer.
REQ-006 clear  input  1  synchronous level clear of statistics and faults.
REQ-007 act_count0, act_count1  output  16 each  activations seen per channel, saturating.
REQ-008 last_on_sec0, last_on_sec1  output  16 each  duration of last completed activation per channel, whole seconds.
REQ-009 fault  output  2  sticky stuck-on flag per channel.
REQ-010 event_valid  output  2  one-cycle pulse per channel when an activation ends.

Function
REQ-011 Per channel, the block SHALL keep pump_prev (registered pump_in), a 32-bit cycle counter cyc, a 16-bit second counter sec, and a state machine IDLE / ON / STUCK.
REQ-012 Rising edge = pump_in[n]=1 and pump_prev[n]=0 at a clock edge; falling edge = pump_in[n]=0 while the channel is in ON or STUCK.
REQ-013 IDLE + rising edge: go ON, cyc<=1, sec<=0, act_count n += 1 (held at 65535 when already 65535), visible after that same edge.
REQ-014 ON + pump_in[n]=1: if cyc == CLOCK_FREQ-1 then cyc<=0, sec<=sec+1, else cyc<=cyc+1; after N consecutive high samples sec SHALL equal floor(N/CLOCK_FREQ).
REQ-015 ON, sec increment reaching MAX_ON_SECONDS: go STUCK, fault[n]<=1 on that edge; counting stops.
REQ-016 ON + falling edge: last_on_sec n <= sec, event_valid[n]=1 for exactly one cycle, go IDLE.
REQ-017 STUCK + falling edge: last_on_sec n <= MAX_ON_SECONDS, event_valid[n]=1 for one cycle, go IDLE; fault[n] stays set.
REQ-018 Channels SHALL be fully independent; simultaneous events on both channels SHALL be processed in the same cycle (event_valid=2'b11 possible).
REQ-019 fault[n] SHALL clear only by reset or clear.
REQ-020 clear=1: act_count n, last_on_sec n and fault[n] SHALL become 0 on that edge for both channels; clear SHALL take priority over a same-edge increment or last_on_sec update.
REQ-021 clear SHALL NOT alter state, cyc, sec or event_valid; an activation in progress continues timing; a channel in STUCK remains STUCK with fault not re-asserted.
REQ-022 A high-for-one-sample activation SHALL count once and report last_on_sec=0 (CLOCK_FREQ>=2).

Reset
REQ-023 reset=0: all outputs 0, all states IDLE, cyc=sec=0, pump_prev=2'b00; reset SHALL override clear and pump_in.
REQ-024 Reset mid-activation SHALL discard it without event_valid; pump_in high on the first post-reset edge SHALL be treated as a rising edge.

Verification (bench with CLOCK_FREQ=10, MAX_ON_SECONDS=3)
REQ-025 pump_in=01 for 25 cycles then 00 -> act_count0=1, last_on_sec0=2, event_valid=01 for one cycle after the first low sample, fault=00.
REQ-026 pump_in=10 held 40 cycles -> fault[1]=1 after the 30th high sample; then 00 -> last_on_sec1=3, event_valid=10 once, fault stays 10.
REQ-027 pump_in=11 for 9 cycles then 00 -> act_count0=act_count1=1, last_on_sec0=last_on_sec1=0, event_valid=11 in one cycle.
REQ-028 clear=1 for one cycle during a 15-cycle channel-0 activation after prior stats -> counts/last/fault 0 immediately; at end last_on_sec0=1, act_count0=0.
REQ-029 reset=0 during 12th high cycle, released with pump_in=01 -> outputs 0, no event_valid, act_count0=1 on first post-reset edge.
REQ-030 65536 one-cycle pulses on channel 0 -> act_count0 saturates at 65535.
